uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Receive buffer that sits directly downstream of the UART receiver. It captures each received byte, indicated by a rising edge on the receiver's done flag, into a first-word-fall-through FIFO.
- It presents the bytes to the CPU-side register interface together with level, overflow and interrupt status.
- It decouples byte arrival from software read latency, so back-to-back frames are not lost.

Parameters:
- AW, 4, log2 of FIFO depth (depth = 2^AW = 16 entries).
- THRESH, 1, fill level (1..2^AW) at or above which the level interrupt asserts.

Ports:
- clk  in  1  system clock.
- RSTn  in  1  reset.
- rx_data  in  8  received byte from the UART receiver; stable while rx_done is high.
- rx_done  in  1  receiver frame-complete flag; level, may stay high for 1 or more cycles per frame.
- rd_en  in  1  CPU pop strobe, one entry per cycle asserted.
- rd_data  out  8  head-of-FIFO byte.
- empty  out  1  FIFO holds 0 entries.
- full  out  1  FIFO holds 2^AW entries.
- level  out  AW+1  current entry count, 0..2^AW.
- overflow  out  1  sticky: a byte was dropped because the FIFO was full.
- ovf_clr  in  1  clears overflow.
- irq_en  in  1  interrupt enable.
- irq  out  1  interrupt request to the NVIC.

Behaviour:
- Reset: reset RSTn, asynchronous, active-low; clock clk. All state flops use async reset. Reset values:
  - wptr = rptr = 0, level = 0, empty = 1, full = 0.
  - overflow = 0, irq = 0, rd_data = 0x00.
  - rx_done_d = 1. This suppresses a spurious push if rx_done is high as reset releases.
  - Storage array is not reset.
- Push detect: rx_done_d <= rx_done every cycle. push = rx_done & ~rx_done_d. Exactly one push per frame, regardless of how long rx_done stays high.
- Write: on push with room available, mem[wptr] <= rx_data and wptr <= wptr+1. wptr is AW bits and wraps modulo 2^AW.
- Pop: pop = rd_en & ~empty, then rptr <= rptr+1 with wrap. rd_en while empty is ignored: no pointer change, no error flag.
- rd_data:
  - Combinational mem[rptr] when !empty, else 0x00.
  - Valid in the same cycle rd_en is sampled, i.e. the byte is consumed at that clock edge.
  - After a push into an empty FIFO, the byte appears on rd_data in the cycle after the push edge.
- Level arithmetic: level is a registered AW+1-bit counter. empty = (level == 0); full = (level == 2^AW).
  - push-accepted only: +1.
  - pop only: -1.
  - both, or neither: unchanged.
- Boundaries:
  - Push while full with simultaneous pop: both proceed, level stays 2^AW, no overflow.
  - Push while full without pop: byte dropped, pointers unchanged, overflow <= 1.
  - Push while empty with rd_en in the same cycle: the pop is ignored and the push is accepted; level becomes 1.
  - Wrap-around: after 2^AW pushes and pops, pointers return to 0 with data order preserved.
- Overflow flag: sticky. ovf_clr=1 clears it next cycle. If set and clear occur in the same cycle, set wins.
- Interrupt: irq = irq_en & ((level >= THRESH) | overflow), registered, so it lags the causing edge by one cycle. irq_en=0 forces irq low in the following cycle.
- Reset mid-operation: asynchronous return to reset values. Any partially stored content is discarded; level reads 0 immediately.

Test Plan:
- Single byte: rx_done high 3 cycles with rx_data=0xA5 -> level=1, empty=0, rd_data=0xA5; irq=1 one cycle later with irq_en=1. Pulse rd_en -> level=0, empty=1, rd_data=0x00, irq=0 next cycle.
- Burst fill: 16 frames carrying 0x00..0x0F -> full=1, level=16. A 17th frame (0xFF) -> overflow=1, level=16. Then 16 pops return 0x00..0x0F in order, with 0xFF absent.
- Full with simultaneous push and pop: FIFO full, rd_en coincident with a rx_done rising edge (0x55) -> level stays 16, overflow stays 0, 0x55 is last out.
- Corner cases:
  - rd_en while empty -> no level change.
  - rx_done high through reset deassertion -> no push.
  - ovf_clr together with an overflowing push -> overflow remains 1.
- Wrap-around and threshold: THRESH=4, 40 push/pop interleaved bytes with an incrementing pattern -> all data in order. irq asserts exactly when level reaches 4 and deasserts when it drops to 3.
- Async reset mid-burst: RSTn low while level=7 -> level=0, empty=1, irq=0, overflow=0 immediately. Next frame (0x3C) is read back correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver. Each rising edge of rx_done is captured
// into a first-word-fall-through FIFO, which the CPU reads with level, overflow and interrupt status.
module uart_rx_fifo #(
    parameter int AW     = 4,
    parameter int THRESH = 1
) (
    input  logic          clk,
    input  logic          RSTn,
    input  logic [7:0]    rx_data,
    input  logic          rx_done,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   level,
    output logic          overflow,
    input  logic          ovf_clr,
    input  logic          irq_en,
    output logic          irq
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] DEPTH_L  = (AW+1)'(DEPTH);
    localparam logic [AW:0] THRESH_L = (AW+1)'(THRESH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   level_q, level_d;
    logic          rx_done_q;
    logic          ovf_q, ovf_d;
    logic          irq_q, irq_d;

    logic push, pop, accept;

    // rx_done_q resets high so a frame flag already asserted at reset release is not taken as a new frame.
    assign push   = rx_done & ~rx_done_q;
    assign pop    = rd_en & ~empty;
    // A full FIFO still has room when the head leaves at the same edge.
    assign accept = push & (~full | pop);

    assign empty    = (level_q == '0);
    assign full     = (level_q == DEPTH_L);
    assign level    = level_q;
    assign overflow = ovf_q;
    assign irq      = irq_q;
    assign rd_data  = empty ? 8'h00 : mem[rptr_q];

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        ovf_d   = ovf_q;
        if (accept) wptr_d = wptr_q + 1'b1;
        if (pop)    rptr_d = rptr_q + 1'b1;
        if (accept && !pop)      level_d = level_q + 1'b1;
        else if (pop && !accept) level_d = level_q - 1'b1;
        if (ovf_clr)         ovf_d = 1'b0;
        if (push && !accept) ovf_d = 1'b1;
        irq_d = irq_en & ((level_q >= THRESH_L) | ovf_q);
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            level_q   <= '0;
            rx_done_q <= 1'b1;
            ovf_q     <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            level_q   <= level_d;
            rx_done_q <= rx_done;
            ovf_q     <= ovf_d;
            irq_q     <= irq_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wptr_q] <= rx_data;
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a THRESH=1 instance and a THRESH=4 instance
// share the same stimulus; expected values are hand-derived or come from a queue model.
module tb_uart_rx_fifo;
    logic       clk = 1'b0;
    logic       RSTn;
    logic [7:0] rx_data;
    logic       rx_done, rd_en, ovf_clr, irq_en;

    logic [7:0] rd_data, rd_data4;
    logic       empty, full, overflow, irq;
    logic       empty4, full4, overflow4, irq4;
    logic [4:0] level, level4;

    int checks = 0;
    int errors = 0;
    logic [7:0] q[$];
    logic [7:0] exp_b;

    always #5 clk = ~clk;

    uart_rx_fifo #(.AW(4), .THRESH(1)) dut (
        .clk(clk), .RSTn(RSTn), .rx_data(rx_data), .rx_done(rx_done), .rd_en(rd_en),
        .rd_data(rd_data), .empty(empty), .full(full), .level(level), .overflow(overflow),
        .ovf_clr(ovf_clr), .irq_en(irq_en), .irq(irq));

    uart_rx_fifo #(.AW(4), .THRESH(4)) dut4 (
        .clk(clk), .RSTn(RSTn), .rx_data(rx_data), .rx_done(rx_done), .rd_en(rd_en),
        .rd_data(rd_data4), .empty(empty4), .full(full4), .level(level4), .overflow(overflow4),
        .ovf_clr(ovf_clr), .irq_en(irq_en), .irq(irq4));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [7:0] b, input int hold);
        rx_data = b;
        rx_done = 1'b1;
        repeat (hold) tick();
        rx_done = 1'b0;
        tick();
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        RSTn = 1'b0; rx_data = 8'h00; rx_done = 1'b1; rd_en = 1'b0; ovf_clr = 1'b0; irq_en = 1'b0;
        #1;
        chk("rst_level", level, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_irq", irq, 0);
        chk("rst_rd_data", rd_data, 8'h00);

        // rx_done held high across reset release must not push
        repeat (2) tick();
        RSTn = 1'b1;
        repeat (2) tick();
        chk("rst_release_nopush", level, 0);
        rx_done = 1'b0;
        irq_en  = 1'b1;
        tick();

        // single byte, rx_done high 3 cycles
        rx_data = 8'hA5; rx_done = 1'b1;
        tick();
        chk("single_level", level, 1);
        chk("single_empty", empty, 0);
        chk("single_rd", rd_data, 8'hA5);
        chk("single_irq_lag", irq, 0);
        tick();
        chk("single_irq", irq, 1);
        tick();
        rx_done = 1'b0;
        tick();
        chk("single_one_push", level, 1);
        pop_one();
        chk("single_pop_level", level, 0);
        chk("single_pop_empty", empty, 1);
        chk("single_pop_rd", rd_data, 8'h00);
        tick();
        chk("single_irq_clear", irq, 0);

        // burst fill, overflow with simultaneous ovf_clr (set wins)
        for (int i = 0; i < 16; i++) frame(8'(i), 1);
        chk("burst_full", full, 1);
        chk("burst_level", level, 16);
        rx_data = 8'hFF; rx_done = 1'b1; ovf_clr = 1'b1;
        tick();
        rx_done = 1'b0; ovf_clr = 1'b0;
        tick();
        chk("burst_ovf", overflow, 1);
        chk("burst_ovf_level", level, 16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("burst_rd%0d", i), rd_data, i);
            pop_one();
        end
        chk("burst_drained", empty, 1);
        chk("burst_ovf_sticky", overflow, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clr", overflow, 0);

        // full with simultaneous push and pop
        for (int i = 0; i < 16; i++) frame(8'(8'h10 + i), 1);
        rx_data = 8'h55; rx_done = 1'b1; rd_en = 1'b1;
        tick();
        rx_done = 1'b0; rd_en = 1'b0;
        tick();
        chk("fullpp_level", level, 16);
        chk("fullpp_ovf", overflow, 0);
        for (int i = 1; i < 17; i++) begin
            exp_b = (i == 16) ? 8'h55 : 8'(8'h10 + i);
            chk($sformatf("fullpp_rd%0d", i), rd_data, exp_b);
            pop_one();
        end
        chk("fullpp_empty", empty, 1);

        // rd_en while empty is ignored
        pop_one();
        chk("empty_pop_level", level, 0);
        chk("empty_pop_rd", rd_data, 8'h00);

        // push into empty with rd_en in the same cycle
        rx_data = 8'h77; rx_done = 1'b1; rd_en = 1'b1;
        tick();
        rx_done = 1'b0; rd_en = 1'b0;
        chk("push_empty_rd_level", level, 1);
        chk("push_empty_rd_data", rd_data, 8'h77);
        tick();
        pop_one();
        chk("push_empty_drain", level, 0);

        // threshold 4 on dut4
        for (int i = 0; i < 3; i++) begin
            frame(8'(8'h80 + i), 1);
            q.push_back(8'(8'h80 + i));
        end
        chk("thr_level3", level4, 3);
        chk("thr_irq_below", irq4, 0);
        rx_data = 8'h83; rx_done = 1'b1;
        tick();
        q.push_back(8'h83);
        chk("thr_level4", level4, 4);
        chk("thr_irq_lag", irq4, 0);
        rx_done = 1'b0;
        tick();
        chk("thr_irq_set", irq4, 1);
        exp_b = q.pop_front();
        chk("thr_head", rd_data4, exp_b);
        pop_one();
        chk("thr_level_drop", level4, 3);
        chk("thr_irq_hold", irq4, 1);
        tick();
        chk("thr_irq_clear", irq4, 0);

        // 40 interleaved push/pop bytes across pointer wrap
        for (int i = 0; i < 40; i++) begin
            exp_b = q.pop_front();
            chk($sformatf("wrap_rd%0d", i), rd_data4, exp_b);
            rx_data = 8'(8'h90 + i); rx_done = 1'b1; rd_en = 1'b1;
            tick();
            rx_done = 1'b0; rd_en = 1'b0;
            q.push_back(8'(8'h90 + i));
            chk("wrap_level", level4, 3);
            tick();
            chk("wrap_irq4", irq4, 0);
            chk("wrap_irq1", irq, 1);
        end
        while (q.size() > 0) begin
            exp_b = q.pop_front();
            chk("wrap_drain_rd", rd_data, exp_b);
            pop_one();
        end
        chk("wrap_empty", empty, 1);

        // irq_en low forces irq low
        frame(8'h01, 1);
        tick();
        chk("irqen_on", irq, 1);
        irq_en = 1'b0;
        tick();
        chk("irqen_off", irq, 0);
        irq_en = 1'b1;
        tick();

        // async reset mid-burst at level 7
        for (int i = 0; i < 6; i++) frame(8'(8'hC0 + i), 1);
        tick();
        chk("mid_level7", level, 7);
        chk("mid_irq_pre", irq, 1);
        @(posedge clk);
        #2 RSTn = 1'b0;
        #1;
        chk("mid_rst_level", level, 0);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_irq", irq, 0);
        chk("mid_rst_ovf", overflow, 0);
        chk("mid_rst_rd", rd_data, 8'h00);
        tick();
        RSTn = 1'b1;
        tick();
        frame(8'h3C, 1);
        chk("post_rst_level", level, 1);
        chk("post_rst_rd", rd_data, 8'h3C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
